ctrl_pipe_stage: RTL

// - Consumer end of the ID-stage control bundle: latches decoded control signals and carries them

---
 rtl/ctrl_pipe_stage.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: carries the decoded ID control bundle through the ID/EX, EX/MEM
// and MEM/WB registers. It also detects load-use hazards, inserts bubbles, flushes
// on a taken branch and freezes the whole pipe on an external stall.
// Optional feature macro: CTRL_PIPE_STATS_EN enables the saturating bubble counter.
// When the macro is undefined, o_bubble_count is tied to 0.
module ctrl_pipe_stage #(
   parameter int unsigned N_BITS_OP  = 6,
   parameter int unsigned N_BITS_REG = 5,
   parameter int unsigned N_BITS_CNT = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_valid,
   input  logic [1:0]            i_alu_op,
   input  logic                  i_alu_src,
   input  logic                  i_reg_dst,
   input  logic                  i_branch,
   input  logic                  i_mem_read,
   input  logic                  i_mem_write,
   input  logic                  i_mem_to_reg,
   input  logic                  i_reg_write,
   input  logic                  i_jump,
   input  logic [N_BITS_OP-1:0]  i_opcode,
   input  logic [N_BITS_REG-1:0] i_rs,
   input  logic [N_BITS_REG-1:0] i_rt,
   input  logic [N_BITS_REG-1:0] i_rd,
   input  logic                  i_branch_taken,
   input  logic                  i_ext_stall,
   output logic                  o_hazard_stall,
   output logic                  o_ex_valid,
   output logic [1:0]            o_ex_alu_op,
   output logic                  o_ex_alu_src,
   output logic                  o_ex_reg_dst,
   output logic                  o_ex_jump,
   output logic [N_BITS_OP-1:0]  o_ex_opcode,
   output logic [N_BITS_REG-1:0] o_ex_rs,
   output logic [N_BITS_REG-1:0] o_ex_rt,
   output logic                  o_mem_valid,
   output logic                  o_mem_branch,
   output logic                  o_mem_read,
   output logic                  o_mem_write,
   output logic                  o_wb_valid,
   output logic                  o_wb_mem_to_reg,
   output logic                  o_wb_reg_write,
   output logic [N_BITS_REG-1:0] o_wb_dst,
   output logic [N_BITS_CNT-1:0] o_bubble_count
);

   // Stage payloads; an all-zero value is a bubble.
   typedef struct packed {
      logic                  valid;
      logic [1:0]            alu_op;
      logic                  alu_src;
      logic                  reg_dst;
      logic                  jump;
      logic [N_BITS_OP-1:0]  opcode;
      logic [N_BITS_REG-1:0] rs;
      logic [N_BITS_REG-1:0] rt;
      logic [N_BITS_REG-1:0] dst;
      logic                  branch;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
      logic                  reg_write;
   } ex_t;

   typedef struct packed {
      logic                  valid;
      logic                  branch;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
      logic                  reg_write;
      logic [N_BITS_REG-1:0] dst;
   } mem_t;

   typedef struct packed {
      logic                  valid;
      logic                  mem_to_reg;
      logic                  reg_write;
      logic [N_BITS_REG-1:0] dst;
   } wb_t;

   ex_t  ex_q,  ex_d,  id_bundle;
   mem_t mem_q, mem_d, ex_to_mem;
   wb_t  wb_q,  wb_d,  mem_to_wb;

   logic src_match;
   logic load_use;
   logic flush;
   logic hazard;

   // ID bundle formatted for EX; the destination register is resolved here.
   always_comb begin
      id_bundle = '0;
      if (i_valid) begin
         id_bundle.valid      = 1'b1;
         id_bundle.alu_op     = i_alu_op;
         id_bundle.alu_src    = i_alu_src;
         id_bundle.reg_dst    = i_reg_dst;
         id_bundle.jump       = i_jump;
         id_bundle.opcode     = i_opcode;
         id_bundle.rs         = i_rs;
         id_bundle.rt         = i_rt;
         id_bundle.dst        = i_reg_dst ? i_rd : i_rt;
         id_bundle.branch     = i_branch;
         id_bundle.mem_read   = i_mem_read;
         id_bundle.mem_write  = i_mem_write;
         id_bundle.mem_to_reg = i_mem_to_reg;
         id_bundle.reg_write  = i_reg_write;
      end
   end

   // Stage-to-stage field subsets.
   always_comb begin
      ex_to_mem            = '0;
      ex_to_mem.valid      = ex_q.valid;
      ex_to_mem.branch     = ex_q.branch;
      ex_to_mem.mem_read   = ex_q.mem_read;
      ex_to_mem.mem_write  = ex_q.mem_write;
      ex_to_mem.mem_to_reg = ex_q.mem_to_reg;
      ex_to_mem.reg_write  = ex_q.reg_write;
      ex_to_mem.dst        = ex_q.dst;
      mem_to_wb            = '0;
      mem_to_wb.valid      = mem_q.valid;
      mem_to_wb.mem_to_reg = mem_q.mem_to_reg;
      mem_to_wb.reg_write  = mem_q.reg_write;
      mem_to_wb.dst        = mem_q.dst;
   end

   // Load-use detection; $0 never hazards, and freeze or flush suppress the request.
   always_comb begin
      src_match = (ex_q.dst == i_rs) | (ex_q.dst == i_rt);
      load_use  = i_valid & ex_q.valid & ex_q.mem_read & (ex_q.dst != '0) & src_match;
      flush     = i_branch_taken & ~i_ext_stall;
      hazard    = load_use & ~i_ext_stall & ~i_branch_taken;
   end

   assign o_hazard_stall = hazard;

   // Next-state of the three pipeline registers: freeze > flush > hazard > advance.
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!i_ext_stall) begin
         wb_d = mem_to_wb;
         if (flush) begin
            ex_d  = '0;
            mem_d = '0;
         end else if (hazard) begin
            ex_d  = '0;
            mem_d = ex_to_mem;
         end else begin
            ex_d  = id_bundle;
            mem_d = ex_to_mem;
         end
      end
   end

   // Pipeline registers with synchronous reset to all-bubble.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign o_ex_valid      = ex_q.valid;
   assign o_ex_alu_op     = ex_q.alu_op;
   assign o_ex_alu_src    = ex_q.alu_src;
   assign o_ex_reg_dst    = ex_q.reg_dst;
   assign o_ex_jump       = ex_q.jump;
   assign o_ex_opcode     = ex_q.opcode;
   assign o_ex_rs         = ex_q.rs;
   assign o_ex_rt         = ex_q.rt;
   assign o_mem_valid     = mem_q.valid;
   assign o_mem_branch    = mem_q.branch;
   assign o_mem_read      = mem_q.mem_read;
   assign o_mem_write     = mem_q.mem_write;
   assign o_wb_valid      = wb_q.valid;
   assign o_wb_mem_to_reg = wb_q.mem_to_reg;
   assign o_wb_reg_write  = wb_q.reg_write;
   assign o_wb_dst        = wb_q.dst;

`ifdef CTRL_PIPE_STATS_EN
   logic [N_BITS_CNT-1:0] bubble_cnt_q, bubble_cnt_d;

   // One count per edge that puts a bubble into EX; saturates at all-ones.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if ((flush | hazard) && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + N_BITS_CNT'(1);
      end
   end

   // Counter register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign o_bubble_count = bubble_cnt_q;
`else
   assign o_bubble_count = '0;
`endif

endmodule
